// File: rtl/addac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// addac_seq_ctrl
// Sequencer for the addac add/accumulate datapath. It accepts a "sum N
// operands" command, clears the accumulator, streams the operands into
// addac, tracks carry-out as a sticky overflow flag and returns the sum.
// It is the sole driver of addac's sel1/sel0/a; addac shares clk.
//
// Optional feature macro: ADDAC_SAT_EN
//   defined   : saturating result (all-ones) once any add carried out
//   undefined : modulo 2**DATA_W wrap-around result (default build)
//
// Reset: rst is asynchronous and active-low.
// ---------------------------------------------------------------------------
module addac_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic              addac_sel1,
    output logic              addac_sel0,
    output logic [DATA_W-1:0] addac_a,
    input  logic              addac_cout,
    input  logic [DATA_W-1:0] addac_s,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_ovf,
    output logic              busy
);

    // addac select encoding {sel1,sel0}
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_ACC  = 2'b10;
    localparam logic [1:0] SEL_CLR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                ovf_q, ovf_d;
    logic [1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   a_q, a_d;
    // iss_pipe tracks any non-hold addac op in flight, add_pipe only adds;
    // bit 0 = registered on the last edge, bit 1 = landed in addac on the last edge
    logic [1:0]          iss_pipe_q, iss_pipe_d;
    logic [1:0]          add_pipe_q, add_pipe_d;
    logic                issue_s, add_s;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_sum_q, res_sum_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                op_ready_q, op_ready_d;
    logic                busy_q, busy_d;
`ifdef ADDAC_SAT_EN
    logic                load_done_q, load_done_d;
`endif

    // Next-state, addac command and result computation
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        // carry is only meaningful in the cycle after an add has landed
        ovf_d       = ovf_q | (add_pipe_q[1] & addac_cout);
        sel_d       = SEL_HOLD;
        a_d         = a_q;
        issue_s     = 1'b0;
        add_s       = 1'b0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
`ifdef ADDAC_SAT_EN
        load_done_d = load_done_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rem_d   = cmd_len;
                    ovf_d   = 1'b0;
                    state_d = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLR: begin
                sel_d   = SEL_CLR;
                issue_s = 1'b1;
                ovf_d   = 1'b0;
`ifdef ADDAC_SAT_EN
                load_done_d = 1'b0;
`endif
                if (rem_q != {CNT_W{1'b0}}) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_DRAIN;
                end
            end

            S_ACC: begin
                if (op_valid && op_ready_q) begin
                    rem_d = rem_q - CNT_W'(1);
                    a_d   = op_data;
`ifdef ADDAC_SAT_EN
                    // once saturated, operands are consumed but not added
                    if (ovf_q) begin
                        sel_d = SEL_HOLD;
                    end else begin
                        sel_d   = SEL_ACC;
                        issue_s = 1'b1;
                        add_s   = 1'b1;
                    end
`else
                    sel_d   = SEL_ACC;
                    issue_s = 1'b1;
                    add_s   = 1'b1;
`endif
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    sel_d = SEL_HOLD;
                end
            end

            S_DRAIN: begin
                // nothing registered on the last edge: addac_s is final
                if (!iss_pipe_q[0]) begin
`ifdef ADDAC_SAT_EN
                    if (ovf_d && !load_done_q) begin
                        sel_d       = SEL_LOAD;
                        a_d         = {DATA_W{1'b1}};
                        issue_s     = 1'b1;
                        load_done_d = 1'b1;
                    end else begin
                        res_sum_d   = addac_s;
                        res_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
`else
                    res_sum_d   = addac_s;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
`endif
                end else begin
                    state_d = S_DRAIN;
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        iss_pipe_d  = {iss_pipe_q[0], issue_s};
        add_pipe_d  = {add_pipe_q[0], add_s};
        cmd_ready_d = (state_d == S_IDLE);
        op_ready_d  = (state_d == S_ACC);
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rem_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            sel_q       <= SEL_HOLD;
            a_q         <= {DATA_W{1'b0}};
            iss_pipe_q  <= 2'b00;
            add_pipe_q  <= 2'b00;
            res_valid_q <= 1'b0;
            res_sum_q   <= {DATA_W{1'b0}};
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ovf_q       <= ovf_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            iss_pipe_q  <= iss_pipe_d;
            add_pipe_q  <= add_pipe_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            cmd_ready_q <= cmd_ready_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ADDAC_SAT_EN
    // Tracks whether the saturation load has already been issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= load_done_d;
        end
    end
`endif

    assign addac_sel1 = sel_q[1];
    assign addac_sel0 = sel_q[0];
    assign addac_a    = a_q;
    assign res_valid  = res_valid_q;
    assign res_sum    = res_sum_q;
    assign res_ovf    = ovf_q;
    assign cmd_ready  = cmd_ready_q;
    assign op_ready   = op_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_addac_seq_ctrl.sv
// Directed testbench for addac_seq_ctrl with a behavioural addac model.
module tb_addac_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_len;
    logic       op_valid, op_ready;
    logic [3:0] op_data;
    logic       sel1, sel0;
    logic [3:0] a;
    logic       m_c;
    logic [3:0] m_s;
    logic       res_valid, res_ready;
    logic [3:0] res_sum;
    logic       res_ovf, busy;

    int n_cmp = 0;
    int n_err = 0;

    addac_seq_ctrl #(.DATA_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .addac_sel1(sel1), .addac_sel0(sel0), .addac_a(a),
        .addac_cout(m_c), .addac_s(m_s),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_ovf(res_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural addac: 00 hold, 01 load, 10 acc, 11 clear
    always @(posedge clk) begin
        case ({sel1, sel0})
            2'b01: m_s <= a;
            2'b10: {m_c, m_s} <= {1'b0, m_s} + {1'b0, a};
            2'b11: begin m_s <= 4'h0; m_c <= 1'b0; end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] d, output bit ok);
        int k;
        ok = 1'b0;
        op_valid = 1'b1;
        op_data  = d;
        for (k = 0; k < 20 && !ok; k++) begin
            if (op_ready) ok = 1'b1;
            tick();
        end
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        int k;
        ok = 1'b0;
        for (k = 0; k < 20 && !ok; k++) begin
            if (res_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 4'h0; op_valid = 1'b0;
        op_data = 4'h0; res_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL rst_op_ready: got %b want 0", op_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_cmp++; if ({res_sum, res_ovf} !== 5'h00) begin n_err++; $display("FAIL rst_result: got %h/%b want 0/0", res_sum, res_ovf); end
        n_cmp++; if ({sel1, sel0, a} !== 6'h00) begin n_err++; $display("FAIL rst_addac: got sel %b%b a %h want 00/0", sel1, sel0, a); end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] ops [3] = '{4'h2, 4'h3, 4'h4};
        cmd_valid = 1'b1; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if ({cmd_ready, busy} !== 2'b01) begin n_err++; $display("FAIL basic_busy: got rdy %b busy %b want 0 1", cmd_ready, busy); end
        tick();
        n_cmp++; if ({sel1, sel0} !== 2'b11) begin n_err++; $display("FAIL basic_clr: got sel %b%b want 11", sel1, sel0); end
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL basic_op_ready: got %b want 1", op_ready); end
        op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_data = ops[i];
            tick();
            n_cmp++; if ({sel1, sel0, a} !== {2'b10, ops[i]}) begin n_err++; $display("FAIL basic_add%0d: got sel %b%b a %h want 10 a %h", i, sel1, sel0, a, ops[i]); end
        end
        op_valid = 1'b0;
        n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL basic_op_ready_off: got %b want 0", op_ready); end
        tick();
        n_cmp++; if ({sel1, sel0, res_valid} !== 3'b000) begin n_err++; $display("FAIL basic_drain: got sel %b%b rv %b want 00 0", sel1, sel0, res_valid); end
        tick();
        n_cmp++; if ({res_valid, res_sum, res_ovf} !== {1'b1, 4'h9, 1'b0}) begin n_err++; $display("FAIL basic_result: got v %b sum %h ovf %b want 1 9 0", res_valid, res_sum, res_ovf); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin n_err++; $display("FAIL basic_accept: got v %b rdy %b busy %b want 0 1 0", res_valid, cmd_ready, busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [3:0] exp_sum;
`ifdef ADDAC_SAT_EN
        exp_sum = 4'hF;
`else
        exp_sum = 4'h1;
`endif
        send_cmd(4'd2);
        tick();
        op_valid = 1'b1; op_data = 4'hF; tick();
        op_data = 4'h2; tick();
        op_valid = 1'b0;
        wait_res(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovf_timeout: got no res_valid want res_valid"); end
        n_cmp++; if ({res_sum, res_ovf} !== {exp_sum, 1'b1}) begin n_err++; $display("FAIL ovf_result: got sum %h ovf %b want %h 1", res_sum, res_ovf, exp_sum); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_zero_len();
        bit opr_seen = 1'b0;
        send_cmd(4'd0);
        for (int i = 1; i <= 3; i++) begin
            opr_seen = opr_seen | op_ready;
            tick();
            opr_seen = opr_seen | op_ready;
            n_cmp++; if (res_valid !== (i == 3)) begin n_err++; $display("FAIL zero_rv_cyc%0d: got %b want %b", i + 1, res_valid, (i == 3)); end
        end
        n_cmp++; if ({res_sum, res_ovf} !== 5'h00) begin n_err++; $display("FAIL zero_result: got sum %h ovf %b want 0 0", res_sum, res_ovf); end
        n_cmp++; if (opr_seen !== 1'b0) begin n_err++; $display("FAIL zero_op_ready: got %b want 0", opr_seen); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_gaps();
        logic [3:0] ops [3] = '{4'h2, 4'h3, 4'h4};
        bit ok;
        send_cmd(4'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 2; g++) begin
                tick();
                n_cmp++; if ({sel1, sel0} !== 2'b00) begin n_err++; $display("FAIL gap_bubble%0d_%0d: got sel %b%b want 00", i, g, sel1, sel0); end
            end
            op_valid = 1'b1; op_data = ops[i];
            tick();
            op_valid = 1'b0;
            n_cmp++; if ({sel1, sel0, a} !== {2'b10, ops[i]}) begin n_err++; $display("FAIL gap_add%0d: got sel %b%b a %h want 10 a %h", i, sel1, sel0, a, ops[i]); end
        end
        wait_res(ok);
        n_cmp++; if ({ok, res_sum, res_ovf} !== {1'b1, 4'h9, 1'b0}) begin n_err++; $display("FAIL gap_result: got ok %b sum %h ovf %b want 1 9 0", ok, res_sum, res_ovf); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit ok;
        send_cmd(4'd1);
        send_op(4'h7, ok);
        wait_res(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL stall_timeout: got no res_valid want res_valid"); end
        cmd_valid = 1'b1; cmd_len = 4'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({res_valid, res_sum, cmd_ready} !== {1'b1, 4'h7, 1'b0}) begin n_err++; $display("FAIL stall_hold%0d: got v %b sum %h rdy %b want 1 7 0", i, res_valid, res_sum, cmd_ready); end
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin n_err++; $display("FAIL stall_release: got v %b rdy %b busy %b want 0 1 0", res_valid, cmd_ready, busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_cmd(4'd3);
        send_op(4'h6, ok);
        n_cmp++; if ({ok, busy, op_ready} !== 3'b111) begin n_err++; $display("FAIL mid_in_acc: got ok %b busy %b opr %b want 1 1 1", ok, busy, op_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, op_ready, cmd_ready, res_valid} !== 4'b0010) begin n_err++; $display("FAIL mid_rst_ctrl: got busy %b opr %b rdy %b rv %b want 0 0 1 0", busy, op_ready, cmd_ready, res_valid); end
        n_cmp++; if ({sel1, sel0, a} !== 6'h00) begin n_err++; $display("FAIL mid_rst_addac: got sel %b%b a %h want 00 0", sel1, sel0, a); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        send_cmd(4'd1);
        send_op(4'h5, ok);
        wait_res(ok);
        n_cmp++; if ({ok, res_sum, res_ovf} !== {1'b1, 4'h5, 1'b0}) begin n_err++; $display("FAIL mid_after: got ok %b sum %h ovf %b want 1 5 0", ok, res_sum, res_ovf); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_gaps();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
